// File: rtl/arcade_memory_map.sv
// CPU memory subsystem for 8080-class arcade cores: banked ROM filled through a
// download port, a work/video RAM window, and a LOAD/CLEAR/RUN sequencer.
module arcade_memory_map #(
    parameter int unsigned ROM_BANKS = 4,
    parameter int unsigned BANK_AW   = 11,
    parameter int unsigned RAM_AW    = 13,
    parameter logic [15:0] RAM_BASE  = 16'h2000,
    parameter int unsigned DL_AW     = 16,
    parameter bit          CLEAR_RAM = 1'b1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [15:0]      Addr,
    input  logic [7:0]       Din,
    input  logic             Rd,
    input  logic             Wr,
    output logic [7:0]       Dout,
    output logic             Dout_valid,
    output logic             Ready,
    input  logic             dl_active,
    input  logic             dl_wr,
    input  logic [DL_AW-1:0] dl_addr,
    input  logic [7:0]       dl_data,
    output logic             dl_ack,
    output logic [7:0]       wp_err_count
);

    localparam int unsigned ROM_DEPTH = ROM_BANKS << BANK_AW;
    localparam int unsigned ROM_IW    = $clog2(ROM_DEPTH);
    localparam int unsigned RAM_SIZE  = 1 << RAM_AW;

    // Windows compared one bit wider so the upper bounds never wrap.
    localparam logic [16:0]      ROM_TOP = 17'(ROM_DEPTH);
    localparam logic [16:0]      RAM_LO  = {1'b0, RAM_BASE};
    localparam logic [16:0]      RAM_HI  = RAM_LO + 17'(RAM_SIZE);
    localparam logic [DL_AW:0]   DL_TOP  = (DL_AW+1)'(ROM_DEPTH);
    localparam logic [RAM_AW-1:0] CLR_MAX = '1;

    typedef enum logic [1:0] {
        S_LOAD,
        S_CLEAR,
        S_RUN
    } state_t;

    state_t            state_q;
    logic [RAM_AW-1:0] clr_q;
    logic [7:0]        dout_q;
    logic              dvalid_q;
    logic              ready_q;
    logic              ack_q;
    logic [7:0]        wp_q;

    logic [7:0] rom [0:ROM_DEPTH-1];
    logic [7:0] ram [0:RAM_SIZE-1];

    logic              rom_hit;
    logic              ram_hit;
    logic              cpu_rd;
    logic              cpu_wr;
    logic              dl_we;
    logic              clr_we;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_widx;
    logic [7:0]        ram_wdata;
    logic [7:0]        rd_data_d;

    always_comb begin
        rom_hit   = {1'b0, Addr} < ROM_TOP;
        ram_hit   = !rom_hit && ({1'b0, Addr} >= RAM_LO) && ({1'b0, Addr} < RAM_HI);
        cpu_rd    = (state_q == S_RUN) && Rd && !Wr;
        cpu_wr    = (state_q == S_RUN) && Wr;
        dl_we     = (state_q == S_LOAD) && dl_wr && ({1'b0, dl_addr} < DL_TOP);
        clr_we    = (state_q == S_CLEAR);
        ram_we    = clr_we || (cpu_wr && ram_hit);
        ram_widx  = clr_we ? clr_q : Addr[RAM_AW-1:0];
        ram_wdata = clr_we ? '0 : Din;
        if (rom_hit) begin
            rd_data_d = rom[Addr[ROM_IW-1:0]];
        end else if (ram_hit) begin
            rd_data_d = ram[Addr[RAM_AW-1:0]];
        end else begin
            rd_data_d = '0;
        end
    end

    // Storage arrays carry no reset; contents survive (unguaranteed) across reset.
    always_ff @(posedge Clock) begin
        if (dl_we) begin
            rom[dl_addr[ROM_IW-1:0]] <= dl_data;
        end
        if (ram_we) begin
            ram[ram_widx] <= ram_wdata;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_LOAD;
            clr_q    <= '0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
            ready_q  <= 1'b0;
            ack_q    <= 1'b0;
            wp_q     <= '0;
        end else begin
            ack_q    <= dl_we;
            dvalid_q <= cpu_rd;
            if (cpu_rd) begin
                dout_q <= rd_data_d;
            end
            if (cpu_wr && !ram_hit && (wp_q != 8'hFF)) begin
                wp_q <= wp_q + 8'd1;
            end
            case (state_q)
                S_LOAD: begin
                    if (!dl_active) begin
                        if (CLEAR_RAM) begin
                            state_q <= S_CLEAR;
                            clr_q   <= '0;
                        end else begin
                            state_q <= S_RUN;
                            ready_q <= 1'b1;
                        end
                    end
                end
                S_CLEAR: begin
                    if (dl_active) begin
                        state_q <= S_LOAD;
                    end else if (clr_q == CLR_MAX) begin
                        state_q <= S_RUN;
                        ready_q <= 1'b1;
                    end else begin
                        clr_q <= clr_q + 1'b1;
                    end
                end
                S_RUN: begin
                    if (dl_active) begin
                        state_q <= S_LOAD;
                        ready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_LOAD;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign Dout         = dout_q;
    assign Dout_valid   = dvalid_q;
    assign Ready        = ready_q;
    assign dl_ack       = ack_q;
    assign wp_err_count = wp_q;

endmodule
